// File: rtl/decode_stage_if.sv
// Signal bundle between the decode stage and its neighbours: the fetch-side IF_ID and
// redirect/stall, the writeback port into the register file, and the ID_EX latch.
interface decode_stage_if;
  logic [63:0]  IF_ID;
  logic         if_valid;
  logic         wb_en;
  logic [4:0]   wb_addr;
  logic [31:0]  wb_data;
  logic [159:0] ID_EX;
  logic         branchFlag;
  logic [31:0]  branch_target;
  logic         stall;
  logic         illegal;

  modport master (
    output IF_ID, if_valid, wb_en, wb_addr, wb_data,
    input  ID_EX, branchFlag, branch_target, stall, illegal
  );

  modport slave (
    input  IF_ID, if_valid, wb_en, wb_addr, wb_data,
    output ID_EX, branchFlag, branch_target, stall, illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: field decode, 32x32 register file with write bypass,
// load-use stall, BEQ/BNE/J resolution with one-slot squash, and the ID_EX latch.
module decode_stage (
  input  logic         clock,
  input  logic         reset,
  decode_stage_if.slave bus
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_OR  = 4'h3;
  localparam logic [3:0] ALU_SLT = 4'h4;
  localparam logic [3:0] ALU_SLL = 4'h5;
  localparam logic [3:0] ALU_LUI = 4'h6;
  localparam logic [3:0] ALU_NOP = 4'hF;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_imm;
    logic       branch;
    logic       jump;
    logic [3:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    ctrl_t       ctrl;
  } id_ex_t;

  logic [31:0] pc, instr;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [31:0] imm_sext;

  assign pc       = bus.IF_ID[63:32];
  assign instr    = bus.IF_ID[31:0];
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};

  logic [31:0] rf_q [32];

  // NOTE: the register file is cleared on reset so software sees all-zero registers;
  // that makes it flops rather than a RAM macro.
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  logic [31:0] rs_val, rt_val;
  assign rs_val = (rs == 5'd0) ? '0 :
                  (bus.wb_en && bus.wb_addr == rs) ? bus.wb_data : rf_q[rs];
  assign rt_val = (rt == 5'd0) ? '0 :
                  (bus.wb_en && bus.wb_addr == rt) ? bus.wb_data : rf_q[rt];

  ctrl_t      ctrl_dec;
  logic [4:0] dest_dec;
  logic       legal;

  // NOTE: combinational logic uses blocking assignments with every output defaulted
  // first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    ctrl_dec = '0;
    dest_dec = '0;
    legal    = 1'b1;
    unique case (opcode)
      OP_RTYPE: begin
        ctrl_dec.reg_write = 1'b1;
        dest_dec           = rd;
        unique case (funct)
          6'h20:   ctrl_dec.alu_op = ALU_ADD;
          6'h22:   ctrl_dec.alu_op = ALU_SUB;
          6'h24:   ctrl_dec.alu_op = ALU_AND;
          6'h25:   ctrl_dec.alu_op = ALU_OR;
          6'h2A:   ctrl_dec.alu_op = ALU_SLT;
          6'h00:   ctrl_dec.alu_op = ALU_SLL;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LUI: begin
        ctrl_dec.reg_write   = 1'b1;
        ctrl_dec.alu_src_imm = 1'b1;
        ctrl_dec.alu_op      = (opcode == OP_LUI) ? ALU_LUI : ALU_ADD;
        dest_dec             = rt;
      end
      OP_LW: begin
        ctrl_dec.reg_write   = 1'b1;
        ctrl_dec.mem_read    = 1'b1;
        ctrl_dec.alu_src_imm = 1'b1;
        ctrl_dec.alu_op      = ALU_ADD;
        dest_dec             = rt;
      end
      OP_SW: begin
        ctrl_dec.mem_write   = 1'b1;
        ctrl_dec.alu_src_imm = 1'b1;
        ctrl_dec.alu_op      = ALU_ADD;
      end
      OP_BEQ, OP_BNE: begin
        ctrl_dec.branch = 1'b1;
        ctrl_dec.alu_op = ALU_SUB;
      end
      OP_J: begin
        ctrl_dec.jump   = 1'b1;
        ctrl_dec.alu_op = ALU_NOP;
      end
      default: legal = 1'b0;
    endcase
  end

  id_ex_t      id_ex_q, id_ex_d;
  logic        squash_q, squash_d;
  logic        branch_flag_q, branch_flag_d;
  logic [31:0] branch_target_q, branch_target_d;
  logic        illegal_q, illegal_d;
  logic        stall, active, taken;

  // A load in ID_EX whose destination feeds this instruction must wait one cycle.
  assign stall = bus.if_valid && !squash_q && id_ex_q.ctrl.mem_read &&
                 (id_ex_q.dest != 5'd0) &&
                 (id_ex_q.dest == rs || id_ex_q.dest == rt);

  assign active = bus.if_valid && !squash_q && !stall;
  assign taken  = active && ((opcode == OP_BEQ && rs_val == rt_val) ||
                             (opcode == OP_BNE && rs_val != rt_val) ||
                             (opcode == OP_J));

  always_comb begin
    id_ex_d    = '0;
    id_ex_d.pc = pc;
    if (active && legal) begin
      id_ex_d.rs_val = rs_val;
      id_ex_d.rt_val = rt_val;
      id_ex_d.imm    = imm_sext;
      id_ex_d.dest   = dest_dec;
      id_ex_d.opcode = opcode;
      id_ex_d.funct  = funct;
      id_ex_d.shamt  = shamt;
      id_ex_d.ctrl   = ctrl_dec;
    end
    illegal_d       = active && !legal;
    squash_d        = taken;
    branch_flag_d   = taken;
    branch_target_d = branch_target_q;
    if (taken) begin
      branch_target_d = (opcode == OP_J) ? {pc[31:26], instr[25:0]}
                                         : pc + 32'd1 + imm_sext;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      id_ex_q         <= '0;
      squash_q        <= 1'b0;
      branch_flag_q   <= 1'b0;
      branch_target_q <= '0;
      illegal_q       <= 1'b0;
    end else begin
      id_ex_q         <= id_ex_d;
      squash_q        <= squash_d;
      branch_flag_q   <= branch_flag_d;
      branch_target_q <= branch_target_d;
      illegal_q       <= illegal_d;
    end
  end

  assign bus.ID_EX         = id_ex_q;
  assign bus.branchFlag    = branch_flag_q;
  assign bus.branch_target = branch_target_q;
  assign bus.stall         = stall;
  assign bus.illegal       = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: hand-encoded instructions with hand-computed
// ID_EX contents, branch results, stall and illegal behaviour.
module tb_decode_stage;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  decode_stage_if bus ();

  decode_stage dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors     = 0;
  int miscompares = 0;

  function automatic logic [159:0] idex(input logic [31:0] pc, rsv, rtv, imm,
                                        input logic [4:0] dest, input logic [5:0] op, funct,
                                        input logic [4:0] shamt, input logic [9:0] ctrl);
    return {pc, rsv, rtv, imm, dest, op, funct, shamt, ctrl};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] instr, input logic valid);
    bus.IF_ID    = {pc, instr};
    bus.if_valid = valid;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [31:0] data);
    bus.wb_en   = en;
    bus.wb_addr = addr;
    bus.wb_data = data;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(32'd0, 32'd0, 1'b0);
    wb(1'b0, 5'd0, 32'd0);
    tick();
    tick();
    vectors++;
    if (bus.ID_EX !== 160'd0) begin
      miscompares++; $display("FAIL reset_id_ex: got %h want 0", bus.ID_EX);
    end
    vectors++;
    if ({bus.branchFlag, bus.branch_target, bus.illegal, bus.stall} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_flags: got bf=%b tgt=%h ill=%b stall=%b want all 0",
               bus.branchFlag, bus.branch_target, bus.illegal, bus.stall);
    end
    reset = 1'b1;
  endtask

  task automatic test_lui();
    logic [159:0] exp;
    drive(32'd0, 32'h3C00_0000, 1'b1);
    tick();
    exp = idex(32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 6'h0F, 6'h00, 5'd0, 10'h246);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL lui_id_ex: got %h want %h", bus.ID_EX, exp);
    end
  endtask

  task automatic test_bypass();
    logic [159:0] exp;
    wb(1'b1, 5'd5, 32'h1234_5678);
    drive(32'd1, 32'h00A0_1820, 1'b1);           // ADD r3,r5,r0
    tick();
    wb(1'b0, 5'd0, 32'd0);
    exp = idex(32'd1, 32'h1234_5678, 32'd0, 32'h1820, 5'd3, 6'h00, 6'h20, 5'd0, 10'h200);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL bypass_id_ex: got %h want %h", bus.ID_EX, exp);
    end
    drive(32'd2, 32'h00A5_3020, 1'b1);           // ADD r6,r5,r5 from stored r5
    tick();
    exp = idex(32'd2, 32'h1234_5678, 32'h1234_5678, 32'h3020, 5'd6, 6'h00, 6'h20, 5'd0, 10'h200);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL regfile_read: got %h want %h", bus.ID_EX, exp);
    end
  endtask

  task automatic test_load_use();
    logic [159:0] exp;
    wb(1'b1, 5'd1, 32'h40);
    drive(32'd3, 32'd0, 1'b0);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    drive(32'd4, 32'h8C22_0000, 1'b1);           // LW r2,0(r1)
    tick();
    exp = idex(32'd4, 32'h40, 32'd0, 32'd0, 5'd2, 6'h23, 6'h00, 5'd0, 10'h340);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL lw_id_ex: got %h want %h", bus.ID_EX, exp);
    end
    drive(32'd5, 32'h0042_2020, 1'b1);           // ADD r4,r2,r2
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++; $display("FAIL load_use_stall: got %b want 1", bus.stall);
    end
    tick();
    exp = idex(32'd5, 32'd0, 32'd0, 32'd0, 5'd0, 6'h00, 6'h00, 5'd0, 10'h000);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL stall_bubble: got %h want %h", bus.ID_EX, exp);
    end
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL stall_one_cycle: got %b want 0", bus.stall);
    end
    tick();
    exp = idex(32'd5, 32'd0, 32'd0, 32'h2020, 5'd4, 6'h00, 6'h20, 5'd0, 10'h200);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL stall_retry: got %h want %h", bus.ID_EX, exp);
    end
    drive(32'd6, 32'h8C22_0000, 1'b1);           // LW r2,0(r1)
    tick();
    drive(32'd7, 32'hAC02_0000, 1'b1);           // SW r2,0(r0): hazard on rt only
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++; $display("FAIL rt_stall: got %b want 1", bus.stall);
    end
    tick();
    tick();
    exp = idex(32'd7, 32'd0, 32'd0, 32'd0, 5'd0, 6'h2B, 6'h00, 5'd0, 10'h0C0);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL sw_id_ex: got %h want %h", bus.ID_EX, exp);
    end
    drive(32'd8, 32'h8C20_0000, 1'b1);           // LW r0,0(r1)
    tick();
    drive(32'd9, 32'h0000_2020, 1'b1);           // ADD r4,r0,r0
    #1;
    vectors++;
    if (bus.stall !== 1'b0) begin
      miscompares++; $display("FAIL r0_no_stall: got %b want 0", bus.stall);
    end
    tick();
  endtask

  task automatic test_branch();
    logic [159:0] exp;
    wb(1'b1, 5'd1, 32'd7);
    drive(32'd0, 32'd0, 1'b0);
    tick();
    wb(1'b1, 5'd2, 32'd7);
    tick();
    wb(1'b0, 5'd0, 32'd0);
    drive(32'd10, 32'h1022_0004, 1'b1);          // BEQ r1,r2,+4
    tick();
    vectors++;
    if (bus.branchFlag !== 1'b1 || bus.branch_target !== 32'd15) begin
      miscompares++;
      $display("FAIL beq_taken: got bf=%b tgt=%h want bf=1 tgt=0000000f",
               bus.branchFlag, bus.branch_target);
    end
    exp = idex(32'd10, 32'd7, 32'd7, 32'd4, 5'd0, 6'h04, 6'h04, 5'd0, 10'h021);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL beq_id_ex: got %h want %h", bus.ID_EX, exp);
    end
    drive(32'd11, 32'h1022_0004, 1'b1);          // wrong-path BEQ must be ignored
    tick();
    exp = idex(32'd11, 32'd0, 32'd0, 32'd0, 5'd0, 6'h00, 6'h00, 5'd0, 10'h000);
    vectors++;
    if (bus.ID_EX !== exp || bus.branchFlag !== 1'b0) begin
      miscompares++;
      $display("FAIL squash_slot: got %h bf=%b want %h bf=0", bus.ID_EX, bus.branchFlag, exp);
    end
    drive(32'd15, 32'h0042_2020, 1'b1);
    tick();
    exp = idex(32'd15, 32'd7, 32'd7, 32'h2020, 5'd4, 6'h00, 6'h20, 5'd0, 10'h200);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL after_squash: got %h want %h", bus.ID_EX, exp);
    end
    drive(32'd20, 32'h1022_FFFE, 1'b1);          // BEQ backwards by 2
    tick();
    vectors++;
    if (bus.branchFlag !== 1'b1 || bus.branch_target !== 32'd19) begin
      miscompares++;
      $display("FAIL beq_negative: got bf=%b tgt=%h want bf=1 tgt=00000013",
               bus.branchFlag, bus.branch_target);
    end
    drive(32'd21, 32'd0, 1'b0);
    tick();
    drive(32'h0400_0005, 32'h0800_0123, 1'b1);   // J 0x123
    tick();
    vectors++;
    if (bus.branchFlag !== 1'b1 || bus.branch_target !== 32'h0400_0123) begin
      miscompares++;
      $display("FAIL j_taken: got bf=%b tgt=%h want bf=1 tgt=04000123",
               bus.branchFlag, bus.branch_target);
    end
    exp = idex(32'h0400_0005, 32'd0, 32'd0, 32'h123, 5'd0, 6'h02, 6'h23, 5'd4, 10'h01F);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL j_id_ex: got %h want %h", bus.ID_EX, exp);
    end
    drive(32'd0, 32'd0, 1'b0);
    tick();
  endtask

  task automatic test_bne();
    logic [159:0] exp;
    drive(32'd30, 32'h1422_0004, 1'b1);          // BNE r1,r2 with r1==r2
    tick();
    exp = idex(32'd30, 32'd7, 32'd7, 32'd4, 5'd0, 6'h05, 6'h04, 5'd0, 10'h021);
    vectors++;
    if (bus.branchFlag !== 1'b0 || bus.ID_EX !== exp) begin
      miscompares++;
      $display("FAIL bne_not_taken: got bf=%b %h want bf=0 %h", bus.branchFlag, bus.ID_EX, exp);
    end
    drive(32'd31, 32'h0042_2020, 1'b1);
    tick();
    exp = idex(32'd31, 32'd7, 32'd7, 32'h2020, 5'd4, 6'h00, 6'h20, 5'd0, 10'h200);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL bne_no_squash: got %h want %h", bus.ID_EX, exp);
    end
  endtask

  task automatic test_illegal();
    logic [159:0] exp;
    drive(32'd40, 32'hFC00_0000, 1'b1);
    tick();
    exp = idex(32'd40, 32'd0, 32'd0, 32'd0, 5'd0, 6'h00, 6'h00, 5'd0, 10'h000);
    vectors++;
    if (bus.illegal !== 1'b1 || bus.ID_EX !== exp) begin
      miscompares++;
      $display("FAIL illegal_opcode: got ill=%b %h want ill=1 %h", bus.illegal, bus.ID_EX, exp);
    end
    drive(32'd41, 32'h0000_003F, 1'b1);          // R-type, unknown funct
    tick();
    exp = idex(32'd41, 32'd0, 32'd0, 32'd0, 5'd0, 6'h00, 6'h00, 5'd0, 10'h000);
    vectors++;
    if (bus.illegal !== 1'b1 || bus.ID_EX !== exp) begin
      miscompares++;
      $display("FAIL illegal_funct: got ill=%b %h want ill=1 %h", bus.illegal, bus.ID_EX, exp);
    end
    drive(32'd42, 32'h0042_2020, 1'b1);
    tick();
    vectors++;
    if (bus.illegal !== 1'b0) begin
      miscompares++; $display("FAIL illegal_pulse: got %b want 0", bus.illegal);
    end
  endtask

  task automatic test_reset_mid_stall();
    logic [159:0] exp;
    drive(32'd50, 32'h8C22_0000, 1'b1);
    tick();
    drive(32'd51, 32'h0042_2020, 1'b1);
    #1;
    vectors++;
    if (bus.stall !== 1'b1) begin
      miscompares++; $display("FAIL pre_reset_stall: got %b want 1", bus.stall);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (bus.ID_EX !== 160'd0 ||
        {bus.branchFlag, bus.branch_target, bus.illegal, bus.stall} !== 35'd0) begin
      miscompares++;
      $display("FAIL reset_mid_stall: got %h bf=%b tgt=%h ill=%b stall=%b want all 0",
               bus.ID_EX, bus.branchFlag, bus.branch_target, bus.illegal, bus.stall);
    end
    reset = 1'b1;
    drive(32'd52, 32'h00A0_1820, 1'b1);          // ADD r3,r5,r0: r5 now cleared
    tick();
    exp = idex(32'd52, 32'd0, 32'd0, 32'h1820, 5'd3, 6'h00, 6'h20, 5'd0, 10'h200);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL r5_cleared: got %h want %h", bus.ID_EX, exp);
    end
    drive(32'd60, 32'h1022_0004, 1'b1);          // r1==r2==0 after reset: taken
    tick();
    vectors++;
    if (bus.branchFlag !== 1'b1) begin
      miscompares++; $display("FAIL beq_zero_taken: got %b want 1", bus.branchFlag);
    end
    reset = 1'b0;
    drive(32'd61, 32'h00A0_1820, 1'b1);
    tick();
    reset = 1'b1;
    tick();
    exp = idex(32'd61, 32'd0, 32'd0, 32'h1820, 5'd3, 6'h00, 6'h20, 5'd0, 10'h200);
    vectors++;
    if (bus.ID_EX !== exp) begin
      miscompares++; $display("FAIL reset_clears_squash: got %h want %h", bus.ID_EX, exp);
    end
  endtask

  initial begin
    test_reset();
    test_lui();
    test_bypass();
    test_load_use();
    test_branch();
    test_bne();
    test_illegal();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
